// File: rtl/mem_stage_if.sv
// Data-cache request/response bus between the MEM stage (master) and the cache (slave).
interface mem_stage_if #(
  parameter int unsigned XLEN = 32
);
  logic            dmem_read;
  logic            dmem_write;
  logic [XLEN-1:0] dmem_address;
  logic [XLEN-1:0] dmem_wdata;
  logic [3:0]      dmem_byte_enable;
  logic            dmem_resp;
  logic [XLEN-1:0] dmem_rdata;

  modport master (
    output dmem_read, dmem_write, dmem_address, dmem_wdata, dmem_byte_enable,
    input  dmem_resp, dmem_rdata
  );

  modport slave (
    input  dmem_read, dmem_write, dmem_address, dmem_wdata, dmem_byte_enable,
    output dmem_resp, dmem_rdata
  );
endinterface

// File: rtl/mem_stage.sv
// Pipeline MEM stage: issues data-cache requests, aligns store lanes, extends load data
// and hands one valid result per instruction to MEM/WB.
module mem_stage #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            exmem_valid,
  input  logic            mem_read,
  input  logic            mem_write,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] alu_out,
  input  logic [XLEN-1:0] rs2_data,
  input  logic            stall_in,
  mem_stage_if.master     dmem,
  output logic            mem_stall,
  output logic [XLEN-1:0] mem_data_out,
  output logic            mem_wb_valid,
  output logic [3:0]      mem_rmask,
  output logic [3:0]      mem_wmask,
  output logic            misalign
);

  typedef enum logic [1:0] {IDLE, BUSY, HOLD} state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [2:0]      f3_q, f3_d;
  logic            rd_q, rd_d, wr_q, wr_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  logic [3:0]      be_q, be_d;
  logic            valid_q, valid_d;
  logic [XLEN-1:0] data_q, data_d;
  logic [3:0]      rmask_q, rmask_d, wmask_q, wmask_d;
  logic            mis_q, mis_d;

  logic            accept, is_mem, is_store, acc_mis, hold_result;
  logic [3:0]      acc_mask;
  logic [XLEN-1:0] acc_wdata, load_val;
  logic [7:0]      ld_byte;
  logic [15:0]     ld_half;

  // funct3[1] set selects a word (covers the undefined 011/110/111 codes)
  assign accept    = exmem_valid && !stall_in;
  assign is_mem    = mem_read || mem_write;
  assign is_store  = mem_write && !mem_read;
  assign acc_mis   = (funct3[1:0] == 2'b01 && alu_out[0]) || (funct3[1] && alu_out[1:0] != 2'b00);
  assign acc_mask  = funct3[1] ? 4'b1111 :
                     funct3[0] ? (4'b0011 << alu_out[1:0]) : (4'b0001 << alu_out[1:0]);
  assign acc_wdata = funct3[1] ? rs2_data :
                     funct3[0] ? {2{rs2_data[15:0]}} : {4{rs2_data[7:0]}};

  assign ld_byte  = dmem.dmem_rdata[{addr_q[1:0], 3'b000} +: 8];
  assign ld_half  = dmem.dmem_rdata[{addr_q[1], 4'b0000} +: 16];
  assign load_val = f3_q[1] ? dmem.dmem_rdata :
                    f3_q[0] ? {{16{!f3_q[2] && ld_half[15]}}, ld_half} :
                              {{24{!f3_q[2] && ld_byte[7]}}, ld_byte};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      f3_q    <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      wdata_q <= '0;
      be_q    <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
      rmask_q <= '0;
      wmask_q <= '0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      f3_q    <= f3_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      rmask_q <= rmask_d;
      wmask_q <= wmask_d;
      mis_q   <= mis_d;
    end
  end

  // The valid cycle itself is spent in IDLE so a new instruction can be accepted
  // alongside it; HOLD is only entered when stall_in blocks that handoff.
  assign hold_result = stall_in && ((state_q == IDLE && valid_q) || state_q == HOLD);

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    f3_d    = f3_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    valid_d = 1'b0;
    data_d  = '0;
    rmask_d = '0;
    wmask_d = '0;
    mis_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (hold_result) begin
          state_d = HOLD;
        end else if (accept) begin
          if (is_mem && !acc_mis) begin
            state_d = BUSY;
            addr_d  = alu_out;
            f3_d    = funct3;
            rd_d    = mem_read;
            wr_d    = is_store;
            wdata_d = acc_wdata;
            be_d    = acc_mask;
          end else begin
            valid_d = 1'b1;
            mis_d   = is_mem;
          end
        end
      end
      BUSY: begin
        if (dmem.dmem_resp) begin
          state_d = IDLE;
          valid_d = 1'b1;
          data_d  = rd_q ? load_val : '0;
          rmask_d = rd_q ? be_q : '0;
          wmask_d = wr_q ? be_q : '0;
        end
      end
      HOLD: begin
        if (!stall_in) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (hold_result) begin
      valid_d = 1'b1;
      data_d  = data_q;
      rmask_d = rmask_q;
      wmask_d = wmask_q;
      mis_d   = mis_q;
    end
  end

  always_comb begin
    dmem.dmem_read        = 1'b0;
    dmem.dmem_write       = 1'b0;
    dmem.dmem_address     = '0;
    dmem.dmem_wdata       = '0;
    dmem.dmem_byte_enable = '0;
    mem_stall             = 1'b0;
    case (state_q)
      IDLE: mem_stall = accept && is_mem && !acc_mis;
      BUSY: begin
        dmem.dmem_read        = rd_q && !dmem.dmem_resp;
        dmem.dmem_write       = wr_q && !dmem.dmem_resp;
        dmem.dmem_address     = {addr_q[XLEN-1:2], 2'b00};
        dmem.dmem_wdata       = wr_q ? wdata_q : '0;
        dmem.dmem_byte_enable = wr_q ? be_q : '0;
        mem_stall             = !dmem.dmem_resp;
      end
      default: ;
    endcase
    mem_wb_valid = valid_q;
    mem_data_out = data_q;
    mem_rmask    = rmask_q;
    mem_wmask    = wmask_q;
    misalign     = mis_q;
  end

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed scenarios plus randomized transactions checked against
// a byte-arithmetic reference model.
module tb_mem_stage;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, exmem_valid, mem_read, mem_write, stall_in;
  logic [2:0]  funct3;
  logic [31:0] alu_out, rs2_data;
  logic        mem_stall, mem_wb_valid, misalign;
  logic [31:0] mem_data_out;
  logic [3:0]  mem_rmask, mem_wmask;

  mem_stage_if #(.XLEN(32)) bus ();

  mem_stage #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .exmem_valid(exmem_valid), .mem_read(mem_read),
    .mem_write(mem_write), .funct3(funct3), .alu_out(alu_out), .rs2_data(rs2_data),
    .stall_in(stall_in), .dmem(bus), .mem_stall(mem_stall), .mem_data_out(mem_data_out),
    .mem_wb_valid(mem_wb_valid), .mem_rmask(mem_rmask), .mem_wmask(mem_wmask),
    .misalign(misalign)
  );

  int unsigned n_checks = 0;
  int unsigned n_pass = 0;

  int unsigned o_stall, o_req_rd, o_req_wr, o_valid, o_first_valid;
  logic [31:0] o_data, o_addr, o_wdata;
  logic [3:0]  o_be, o_rmask, o_wmask;
  logic        o_mis, o_unstable, o_data_changed;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    exmem_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0; funct3 = 3'b000;
    alu_out = 32'd0; rs2_data = 32'd0; stall_in = 1'b0;
    bus.dmem_resp = 1'b0; bus.dmem_rdata = 32'd0;
  endtask

  // Reference model: expected result of one instruction from byte arithmetic.
  function automatic void model(input logic rd, input logic wr, input logic [2:0] f3,
                                input logic [31:0] addr, input logic [31:0] rs2,
                                input logic [31:0] rdat, output bit issue, output bit e_mis,
                                output logic [31:0] e_data, output logic [31:0] e_wdata,
                                output logic [3:0] e_rmask, output logic [3:0] e_wmask);
    int unsigned nb, a;
    longint unsigned v, lim;
    logic [3:0] mask;
    nb = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    a = addr % 4;
    e_mis = (rd || wr) && (a % nb != 0);
    issue = (rd || wr) && !e_mis;
    mask = 4'(((32'd1 << nb) - 1) << a);
    lim = 64'd1 << (8 * nb);
    v = ({32'd0, rdat} >> (8 * a)) % lim;
    if (!f3[2] && nb < 4 && v >= lim / 2) v = v - lim;
    e_data  = (issue && rd) ? v[31:0] : 32'd0;
    e_rmask = (issue && rd) ? mask : 4'd0;
    e_wmask = (issue && wr && !rd) ? mask : 4'd0;
    e_wdata = (nb == 1) ? (rs2 % 256) * 32'h01010101 :
              (nb == 2) ? (rs2 % 65536) * 32'h00010001 : rs2;
  endfunction

  // Drives one instruction, answers the cache after rwait request cycles, applies
  // stall_in for stall_n cycles starting at the expected valid cycle, records what it sees.
  task automatic run_txn(input logic rd, input logic wr, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] rs2,
                         input logic [31:0] rdat, input int unsigned rwait,
                         input int unsigned stall_n);
    bit issue, mis;
    logic [31:0] ed, ew;
    logic [3:0] er, em;
    int unsigned cv, last;
    model(rd, wr, f3, addr, rs2, rdat, issue, mis, ed, ew, er, em);
    cv = issue ? rwait + 2 : 1;
    last = cv + stall_n + 1;
    o_stall = 0; o_req_rd = 0; o_req_wr = 0; o_valid = 0; o_first_valid = 999;
    o_data = '0; o_addr = '0; o_wdata = '0; o_be = '0; o_rmask = '0; o_wmask = '0;
    o_mis = 1'b0; o_unstable = 1'b0; o_data_changed = 1'b0;
    exmem_valid = 1'b1; mem_read = rd; mem_write = wr; funct3 = f3;
    alu_out = addr; rs2_data = rs2; stall_in = 1'b0;
    bus.dmem_resp = 1'b0; bus.dmem_rdata = $urandom;
    for (int unsigned c = 0; c <= last; c++) begin
      if (c > 0) begin
        exmem_valid = 1'b0; mem_read = 1'($urandom); mem_write = 1'($urandom);
        funct3 = 3'($urandom); alu_out = $urandom; rs2_data = $urandom;
        bus.dmem_resp = issue && (c == rwait + 1);
        bus.dmem_rdata = bus.dmem_resp ? rdat : $urandom;
        stall_in = (c >= cv) ? (c < cv + stall_n) : (issue ? 1'($urandom) : 1'b0);
      end
      #1;
      if (mem_stall) o_stall++;
      if (bus.dmem_read || bus.dmem_write) begin
        if (o_req_rd + o_req_wr == 0) begin
          o_addr = bus.dmem_address; o_wdata = bus.dmem_wdata; o_be = bus.dmem_byte_enable;
        end else if (o_addr !== bus.dmem_address || o_wdata !== bus.dmem_wdata ||
                     o_be !== bus.dmem_byte_enable) begin
          o_unstable = 1'b1;
        end
        if (bus.dmem_read) o_req_rd++;
        if (bus.dmem_write) o_req_wr++;
      end
      if (mem_wb_valid) begin
        if (o_valid == 0) begin
          o_first_valid = c; o_data = mem_data_out; o_rmask = mem_rmask;
          o_wmask = mem_wmask; o_mis = misalign;
        end else if (mem_data_out !== o_data) begin
          o_data_changed = 1'b1;
        end
        o_valid++;
      end
      tick();
    end
    idle_inputs();
  endtask

  task automatic test_reset;
    idle_inputs();
    rst = 1'b1;
    tick(); tick();
    #1;
    n_checks++; if ({mem_stall, mem_wb_valid, misalign, bus.dmem_read, bus.dmem_write} !== 5'b0) $display("FAIL reset_ctrl: got %b expected 00000", {mem_stall, mem_wb_valid, misalign, bus.dmem_read, bus.dmem_write}); else n_pass++;
    n_checks++; if (mem_data_out !== 32'd0) $display("FAIL reset_data: got %h expected 0", mem_data_out); else n_pass++;
    n_checks++; if ({mem_rmask, mem_wmask, bus.dmem_byte_enable} !== 12'd0) $display("FAIL reset_masks: got %h expected 0", {mem_rmask, mem_wmask, bus.dmem_byte_enable}); else n_pass++;
    n_checks++; if ({bus.dmem_address, bus.dmem_wdata} !== 64'd0) $display("FAIL reset_bus: got %h expected 0", {bus.dmem_address, bus.dmem_wdata}); else n_pass++;
    rst = 1'b0;
    tick();
  endtask

  task automatic test_store_word;
    run_txn(1'b0, 1'b1, 3'b010, 32'h0000_1000, 32'hDEAD_BEEF, 32'd0, 3, 0);
    n_checks++; if (o_req_wr !== 3) $display("FAIL sw_write_cycles: got %0d expected 3", o_req_wr); else n_pass++;
    n_checks++; if (o_addr !== 32'h1000) $display("FAIL sw_addr: got %h expected 00001000", o_addr); else n_pass++;
    n_checks++; if (o_be !== 4'b1111) $display("FAIL sw_be: got %b expected 1111", o_be); else n_pass++;
    n_checks++; if (o_wdata !== 32'hDEAD_BEEF) $display("FAIL sw_wdata: got %h expected deadbeef", o_wdata); else n_pass++;
    n_checks++; if (o_unstable !== 1'b0) $display("FAIL sw_stable: got %b expected 0", o_unstable); else n_pass++;
    n_checks++; if (o_stall !== 4) $display("FAIL sw_stall: got %0d expected 4", o_stall); else n_pass++;
    n_checks++; if (o_valid !== 1) $display("FAIL sw_valid_cycles: got %0d expected 1", o_valid); else n_pass++;
    n_checks++; if ({o_wmask, o_rmask} !== 8'b1111_0000) $display("FAIL sw_masks: got %b expected 11110000", {o_wmask, o_rmask}); else n_pass++;
  endtask

  task automatic test_store_byte;
    run_txn(1'b0, 1'b1, 3'b000, 32'h0000_1003, 32'h0000_00A5, 32'd0, 1, 0);
    n_checks++; if (o_be !== 4'b1000) $display("FAIL sb_be: got %b expected 1000", o_be); else n_pass++;
    n_checks++; if (o_wdata !== 32'hA5A5_A5A5) $display("FAIL sb_wdata: got %h expected a5a5a5a5", o_wdata); else n_pass++;
    n_checks++; if (o_addr !== 32'h1000) $display("FAIL sb_addr: got %h expected 00001000", o_addr); else n_pass++;
    n_checks++; if (o_wmask !== 4'b1000) $display("FAIL sb_wmask: got %b expected 1000", o_wmask); else n_pass++;
  endtask

  task automatic test_loads;
    run_txn(1'b1, 1'b0, 3'b000, 32'h0000_2002, 32'd0, 32'h12F4_0000, 0, 0);
    n_checks++; if (o_data !== 32'hFFFF_FFF4) $display("FAIL lb_data: got %h expected fffffff4", o_data); else n_pass++;
    n_checks++; if (o_rmask !== 4'b0100) $display("FAIL lb_rmask: got %b expected 0100", o_rmask); else n_pass++;
    n_checks++; if (o_first_valid !== 2) $display("FAIL lb_latency: got %0d expected 2", o_first_valid); else n_pass++;
    n_checks++; if (o_stall !== 1) $display("FAIL lb_stall: got %0d expected 1", o_stall); else n_pass++;
    run_txn(1'b1, 1'b0, 3'b100, 32'h0000_2002, 32'd0, 32'h12F4_0000, 2, 0);
    n_checks++; if (o_data !== 32'h0000_00F4) $display("FAIL lbu_data: got %h expected 000000f4", o_data); else n_pass++;
    n_checks++; if (o_req_rd !== 2) $display("FAIL lbu_read_cycles: got %0d expected 2", o_req_rd); else n_pass++;
    run_txn(1'b1, 1'b0, 3'b101, 32'h0000_2002, 32'd0, 32'h8001_0000, 1, 0);
    n_checks++; if (o_data !== 32'h0000_8001) $display("FAIL lhu_data: got %h expected 00008001", o_data); else n_pass++;
    n_checks++; if (o_rmask !== 4'b1100) $display("FAIL lhu_rmask: got %b expected 1100", o_rmask); else n_pass++;
  endtask

  task automatic test_misalign;
    run_txn(1'b1, 1'b0, 3'b001, 32'h0000_2001, 32'd0, 32'h1234_5678, 1, 0);
    n_checks++; if (o_req_rd + o_req_wr !== 0) $display("FAIL lh_mis_request: got %0d expected 0", o_req_rd + o_req_wr); else n_pass++;
    n_checks++; if (o_stall !== 0) $display("FAIL lh_mis_stall: got %0d expected 0", o_stall); else n_pass++;
    n_checks++; if (o_first_valid !== 1) $display("FAIL lh_mis_latency: got %0d expected 1", o_first_valid); else n_pass++;
    n_checks++; if ({o_mis, o_data, o_rmask, o_wmask} !== {1'b1, 40'd0}) $display("FAIL lh_mis_result: got %b/%h expected 1/0", o_mis, o_data); else n_pass++;
    run_txn(1'b0, 1'b1, 3'b010, 32'h0000_1002, 32'h5555_AAAA, 32'd0, 1, 0);
    n_checks++; if ({o_mis, o_req_wr, o_wmask} !== {1'b1, 32'd0, 4'd0}) $display("FAIL sw_mis: got mis=%b writes=%0d wmask=%b expected 1/0/0000", o_mis, o_req_wr, o_wmask); else n_pass++;
  endtask

  task automatic test_nonmem;
    run_txn(1'b0, 1'b0, 3'b001, 32'h0000_0001, 32'hFFFF_FFFF, 32'd0, 0, 0);
    n_checks++; if (o_first_valid !== 1 || o_valid !== 1) $display("FAIL nonmem_valid: got first=%0d count=%0d expected 1/1", o_first_valid, o_valid); else n_pass++;
    n_checks++; if ({o_mis, o_data, o_rmask, o_wmask, o_stall} !== 73'd0) $display("FAIL nonmem_result: got mis=%b data=%h stall=%0d expected zeros", o_mis, o_data, o_stall); else n_pass++;
  endtask

  task automatic test_hold;
    run_txn(1'b1, 1'b0, 3'b010, 32'h0000_2004, 32'd0, 32'h89AB_CDEF, 1, 2);
    n_checks++; if (o_valid !== 3) $display("FAIL hold_valid_cycles: got %0d expected 3", o_valid); else n_pass++;
    n_checks++; if (o_data !== 32'h89AB_CDEF || o_data_changed !== 1'b0) $display("FAIL hold_data: got %h changed=%b expected 89abcdef/0", o_data, o_data_changed); else n_pass++;
    n_checks++; if (o_first_valid !== 3) $display("FAIL hold_latency: got %0d expected 3", o_first_valid); else n_pass++;
  endtask

  task automatic test_reset_busy;
    int unsigned seen = 0;
    exmem_valid = 1'b1; mem_read = 1'b1; mem_write = 1'b0; funct3 = 3'b010; alu_out = 32'h3000;
    tick();
    exmem_valid = 1'b0; mem_read = 1'b0;
    #1;
    n_checks++; if (bus.dmem_read !== 1'b1) $display("FAIL rstbusy_req: got %b expected 1", bus.dmem_read); else n_pass++;
    rst = 1'b1;
    tick();
    rst = 1'b0; bus.dmem_resp = 1'b1; bus.dmem_rdata = 32'hCAFE_F00D;
    #1;
    n_checks++; if ({mem_stall, bus.dmem_read, bus.dmem_address} !== 34'd0) $display("FAIL rstbusy_outputs: got stall=%b read=%b addr=%h expected 0", mem_stall, bus.dmem_read, bus.dmem_address); else n_pass++;
    tick();
    bus.dmem_resp = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      if (mem_wb_valid || mem_data_out !== 32'd0 || mem_rmask !== 4'd0) seen++;
      tick();
    end
    n_checks++; if (seen !== 0) $display("FAIL rstbusy_no_valid: got %0d result cycles expected 0", seen); else n_pass++;
  endtask

  task automatic test_back_to_back;
    logic [5:0] vpat = '0;
    for (int c = 0; c < 6; c++) begin
      exmem_valid = (c < 4); mem_read = 1'b0; mem_write = 1'b0;
      funct3 = 3'($urandom); alu_out = $urandom;
      #1;
      vpat[c] = mem_wb_valid && (mem_data_out === 32'd0);
      tick();
    end
    idle_inputs();
    n_checks++; if (vpat !== 6'b011110) $display("FAIL b2b_valid_pattern: got %b expected 011110", vpat); else n_pass++;
  endtask

  task automatic test_random;
    bit issue, mis;
    logic [31:0] ed, ew, addr, rs2, rdat;
    logic [3:0] er, em;
    logic [2:0] f3;
    logic rd, wr;
    int unsigned kind, rwait, stall_n;
    for (int i = 0; i < 40; i++) begin
      kind = $urandom % 3;
      rd = (kind == 0); wr = (kind == 1);
      f3 = 3'($urandom); addr = $urandom; rs2 = $urandom; rdat = $urandom;
      rwait = $urandom % 4; stall_n = $urandom % 3;
      model(rd, wr, f3, addr, rs2, rdat, issue, mis, ed, ew, er, em);
      run_txn(rd, wr, f3, addr, rs2, rdat, rwait, stall_n);
      n_checks++; if (o_data !== ed) $display("FAIL rnd%0d_data: got %h expected %h", i, o_data, ed); else n_pass++;
      n_checks++; if ({o_rmask, o_wmask, o_mis} !== {er, em, mis}) $display("FAIL rnd%0d_flags: got %b/%b/%b expected %b/%b/%b", i, o_rmask, o_wmask, o_mis, er, em, mis); else n_pass++;
      n_checks++; if (o_first_valid !== (issue ? rwait + 2 : 1) || o_valid !== stall_n + 1) $display("FAIL rnd%0d_timing: got first=%0d count=%0d expected %0d/%0d", i, o_first_valid, o_valid, issue ? rwait + 2 : 1, stall_n + 1); else n_pass++;
      n_checks++; if (o_stall !== (issue ? rwait + 1 : 0) || o_req_rd + o_req_wr !== (issue ? rwait : 0)) $display("FAIL rnd%0d_stall_req: got stall=%0d req=%0d expected %0d/%0d", i, o_stall, o_req_rd + o_req_wr, issue ? rwait + 1 : 0, issue ? rwait : 0); else n_pass++;
      n_checks++; if (o_unstable !== 1'b0 || o_data_changed !== 1'b0) $display("FAIL rnd%0d_stability: got bus=%b data=%b expected 0/0", i, o_unstable, o_data_changed); else n_pass++;
      if (issue && wr && rwait > 0) begin
        n_checks++; if ({o_addr, o_be, o_wdata} !== {addr & 32'hFFFF_FFFC, em, ew}) $display("FAIL rnd%0d_store_bus: got %h/%b/%h expected %h/%b/%h", i, o_addr, o_be, o_wdata, addr & 32'hFFFF_FFFC, em, ew); else n_pass++;
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    test_reset();
    test_store_word();
    test_store_byte();
    test_loads();
    test_misalign();
    test_nonmem();
    test_hold();
    test_reset_busy();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
